// File: rtl/apb_burst_modport_if.sv
// Bus bundle for the APB-to-burst bridge: APB slave side plus the byte-wide
// outbound (master) and inbound (sink) burst links.
interface apb_burst_modport_if;
  logic [8:0] paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [7:0] prdata;
  logic       plsverr;
  logic       apb_rd_done;
  logic       idle;
  logic [7:0] data_burst_out;
  logic       db_valid;
  logic       last;
  logic [7:0] db_length;
  logic       burst_ready;
  logic [7:0] data_burst_in;
  logic       burst_valid;
  logic       burst_last;
  logic       db_ready;

  modport slave (
    input  paddr, psel, penable, pwrite, pwdata,
    input  burst_ready, data_burst_in, burst_valid, burst_last,
    output prdata, plsverr, apb_rd_done, idle,
    output data_burst_out, db_valid, last, db_length, db_ready
  );

  modport master (
    output paddr, psel, penable, pwrite, pwdata,
    output burst_ready, data_burst_in, burst_valid, burst_last,
    input  prdata, plsverr, apb_rd_done, idle,
    input  data_burst_out, db_valid, last, db_length, db_ready
  );
endinterface

// File: rtl/apb_burst_modport.sv
// APB-programmed bridge: 16-byte TX buffer sent as an outbound burst, and an
// inbound burst captured into a 16-byte RX buffer for APB readback.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no burst in flight; APB may program buffers, LEN, CTRL
// TX_WAIT | go_tx accepted, waiting for burst_ready to present byte 0
// TX      | outbound burst running, one byte per valid&ready handshake
// RX      | db_ready high, capturing inbound bytes into RXBUF
module apb_burst_modport (
  input logic              clk,
  input logic              rst_n,
  apb_burst_modport_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_TX_WAIT, S_TX, S_RX} state_t;

  state_t     state, state_nxt;
  logic [7:0] txbuf [16];
  logic [7:0] rxbuf [16];
  logic [4:0] len;
  logic [4:0] rx_count;
  logic [3:0] tx_idx;
  logic       tx_done;
  logic       rx_done;

  logic       is_tx, is_rx, is_len, is_ctrl, is_stat;
  logic       setup, err, wr_commit, rx_acc, tx_hs;
  logic [7:0] rd_val;

  assign is_tx   = (bus.paddr[8:4] == 5'h00);
  assign is_rx   = (bus.paddr[8:4] == 5'h01);
  assign is_len  = (bus.paddr == 9'h100);
  assign is_ctrl = (bus.paddr == 9'h101);
  assign is_stat = (bus.paddr == 9'h102);

  assign setup = bus.psel && !bus.penable;
  // The error flag registered at the setup edge gates the commit at the access edge.
  assign wr_commit = bus.psel && bus.penable && bus.pwrite && !bus.plsverr;
  assign rx_acc    = (state == S_RX) && bus.burst_valid && bus.db_ready;
  assign tx_hs     = (state == S_TX) && bus.db_valid && bus.burst_ready;
  assign bus.idle  = (state == S_IDLE);

  always_comb begin
    err = 1'b0;
    if (!(is_tx || is_rx || is_len || is_ctrl || is_stat)) begin
      err = 1'b1;
    end else if (bus.pwrite) begin
      if (is_rx || is_stat)                               err = 1'b1;
      if (is_len && (bus.pwdata == 8'd0 || bus.pwdata > 8'd16)) err = 1'b1;
      if (is_ctrl && bus.pwdata[1:0] == 2'b11)             err = 1'b1;
      if ((is_tx || is_len || is_ctrl) && state != S_IDLE) err = 1'b1;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    if (is_tx)        rd_val = txbuf[bus.paddr[3:0]];
    else if (is_rx)   rd_val = rxbuf[bus.paddr[3:0]];
    else if (is_len)  rd_val = {3'b000, len};
    else if (is_stat) rd_val = {rx_count, tx_done, rx_done, state == S_IDLE};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (wr_commit && is_ctrl && bus.pwdata[0])      state_nxt = S_TX_WAIT;
        else if (wr_commit && is_ctrl && bus.pwdata[1]) state_nxt = S_RX;
      end
      S_TX_WAIT: if (bus.burst_ready)     state_nxt = S_TX;
      S_TX:      if (tx_hs && bus.last)   state_nxt = S_IDLE;
      S_RX:      if (rx_acc && (bus.burst_last || rx_count == 5'd15)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.prdata         <= 8'h00;
      bus.plsverr        <= 1'b0;
      bus.apb_rd_done    <= 1'b0;
      bus.data_burst_out <= 8'h00;
      bus.db_valid       <= 1'b0;
      bus.last           <= 1'b0;
      bus.db_length      <= 8'h00;
      bus.db_ready       <= 1'b0;
      len                <= 5'd1;
      rx_count           <= 5'd0;
      tx_idx             <= 4'd0;
      tx_done            <= 1'b0;
      rx_done            <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        txbuf[i] <= 8'h00;
        rxbuf[i] <= 8'h00;
      end
    end else begin
      if (setup) begin
        bus.plsverr     <= err;
        bus.apb_rd_done <= !bus.pwrite && !err;
        if (!bus.pwrite) bus.prdata <= err ? 8'h00 : rd_val;
      end else begin
        bus.plsverr     <= 1'b0;
        bus.apb_rd_done <= 1'b0;
      end

      if (wr_commit && is_tx)  txbuf[bus.paddr[3:0]] <= bus.pwdata;
      if (wr_commit && is_len) len <= bus.pwdata[4:0];
      if (wr_commit && is_ctrl) begin
        if (bus.pwdata[0]) begin
          tx_done <= 1'b0;
        end else if (bus.pwdata[1]) begin
          rx_done      <= 1'b0;
          rx_count     <= 5'd0;
          bus.db_ready <= 1'b1;
        end else begin
          tx_done <= 1'b0;
          rx_done <= 1'b0;
        end
      end

      case (state)
        S_TX_WAIT: begin
          if (bus.burst_ready) begin
            bus.data_burst_out <= txbuf[0];
            bus.db_valid       <= 1'b1;
            bus.db_length      <= {3'b000, len};
            bus.last           <= (len == 5'd1);
            tx_idx             <= 4'd1;
          end
        end
        S_TX: begin
          if (tx_hs) begin
            if (bus.last) begin
              bus.db_valid  <= 1'b0;
              bus.last      <= 1'b0;
              bus.db_length <= 8'h00;
              tx_done       <= 1'b1;
            end else begin
              bus.data_burst_out <= txbuf[tx_idx];
              bus.last           <= ({1'b0, tx_idx} == len - 5'd1);
              tx_idx             <= tx_idx + 4'd1;
            end
          end
        end
        S_RX: begin
          if (rx_acc) begin
            rxbuf[rx_count[3:0]] <= bus.data_burst_in;
            rx_count             <= rx_count + 5'd1;
            if (bus.burst_last || rx_count == 5'd15) begin
              bus.db_ready <= 1'b0;
              rx_done      <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_burst_modport.sv
// Scoreboard bench for apb_burst_modport: APB and outbound-burst expectations
// are queued by the stimulus and checked by a negedge monitor.
module tb_apb_burst_modport;
  logic clk = 1'b0;
  logic rst_n;

  apb_burst_modport_if bus ();

  apb_burst_modport dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic       err;
    logic [7:0] data;
  } apb_exp_t;

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic [7:0] n;
  } tx_exp_t;

  apb_exp_t apb_q[$];
  tx_exp_t  tx_q[$];
  int checks = 0;
  int errors = 0;

  logic       prev_valid = 1'b0;
  logic       prev_hs    = 1'b0;
  logic [7:0] prev_data  = 8'h00;
  logic       prev_last  = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: APB access-phase responses and outbound handshakes.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.psel && bus.penable) begin
        if (apb_q.size() == 0) begin
          chk("apb_unexpected", 1, 0);
        end else begin
          apb_exp_t e;
          e = apb_q.pop_front();
          chk("plsverr", bus.plsverr, e.err);
          chk("apb_rd_done", bus.apb_rd_done, !e.wr && !e.err);
          if (!e.wr && !e.err) chk("prdata", bus.prdata, e.data);
        end
      end else begin
        chk("apb_flags_low", {bus.plsverr, bus.apb_rd_done}, 2'b00);
      end

      if (prev_valid && !prev_hs && bus.db_valid)
        chk("tx_hold", {bus.data_burst_out, bus.last}, {prev_data, prev_last});
      if (!bus.db_valid) chk("db_length_idle", bus.db_length, 0);
      if (bus.db_valid && bus.burst_ready) begin
        if (tx_q.size() == 0) begin
          chk("tx_unexpected", 1, 0);
        end else begin
          tx_exp_t t;
          t = tx_q.pop_front();
          chk("tx_data", bus.data_burst_out, t.d);
          chk("tx_last", bus.last, t.l);
          chk("tx_length", bus.db_length, t.n);
        end
      end
      prev_valid = bus.db_valid;
      prev_hs    = bus.db_valid && bus.burst_ready;
      prev_data  = bus.data_burst_out;
      prev_last  = bus.last;
    end
  end

  task automatic apb(input logic wr, input logic [8:0] a, input logic [7:0] d,
                     input logic err, input logic [7:0] exp);
    apb_exp_t e;
    e.wr = wr; e.err = err; e.data = exp;
    apb_q.push_back(e);
    @(posedge clk); #1;
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = wr; bus.paddr = a; bus.pwdata = d;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    @(posedge clk); #1;
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
  endtask

  task automatic push_tx(input logic [7:0] d, input logic l, input logic [7:0] n);
    tx_exp_t t;
    t.d = d; t.l = l; t.n = n;
    tx_q.push_back(t);
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int n = 0;
    while (!bus.idle && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk(nm, bus.idle, 1);
  endtask

  task automatic push_abc3();
    push_tx(8'hA1, 1'b0, 8'd3);
    push_tx(8'hB2, 1'b0, 8'd3);
    push_tx(8'hC3, 1'b1, 8'd3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic pat [4];
    int acc;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    rst_n = 1'b0;
    bus.paddr = '0; bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.pwdata = '0;
    bus.burst_ready = 0; bus.data_burst_in = '0; bus.burst_valid = 0; bus.burst_last = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_outputs",
        {bus.prdata, bus.plsverr, bus.apb_rd_done, bus.idle, bus.data_burst_out,
         bus.db_valid, bus.last, bus.db_length, bus.db_ready},
        {8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
    rst_n = 1'b1;
    apb(0, 9'h102, 8'h00, 0, 8'h01);
    apb(0, 9'h100, 8'h00, 0, 8'h01);

    // TX of 3 bytes with burst_ready held high
    apb(1, 9'h000, 8'hA1, 0, 8'h00);
    apb(1, 9'h001, 8'hB2, 0, 8'h00);
    apb(1, 9'h002, 8'hC3, 0, 8'h00);
    apb(1, 9'h100, 8'h03, 0, 8'h00);
    apb(0, 9'h100, 8'h00, 0, 8'h03);
    apb(0, 9'h001, 8'h00, 0, 8'hB2);
    bus.burst_ready = 1'b1;
    push_abc3();
    apb(1, 9'h101, 8'h01, 0, 8'h00);
    chk("tx_left_idle", bus.idle, 0);
    wait_idle(20, "tx_done_idle");
    chk("tx_q_drained", tx_q.size(), 0);
    apb(0, 9'h102, 8'h00, 0, 8'h05);

    // TX with backpressure pattern 1,0,0,1
    bus.burst_ready = 1'b0;
    push_abc3();
    apb(1, 9'h101, 8'h01, 0, 8'h00);
    for (int i = 0; i < 40; i++) begin
      bus.burst_ready = pat[i % 4];
      @(posedge clk); #1;
      if (bus.idle) break;
    end
    chk("bp_idle", bus.idle, 1);
    chk("bp_q_drained", tx_q.size(), 0);

    // CTRL=0 clears flags
    apb(1, 9'h101, 8'h00, 0, 8'h00);
    apb(0, 9'h102, 8'h00, 0, 8'h01);
    apb(0, 9'h101, 8'h00, 0, 8'h00);

    // RX of 4 bytes
    apb(1, 9'h101, 8'h02, 0, 8'h00);
    chk("rx_db_ready_on", bus.db_ready, 1);
    chk("rx_not_idle", bus.idle, 0);
    for (int i = 0; i < 4; i++) begin
      bus.data_burst_in = 8'h11 * (i + 1);
      bus.burst_valid = 1'b1;
      bus.burst_last = (i == 3);
      @(posedge clk); #1;
    end
    bus.burst_valid = 1'b0; bus.burst_last = 1'b0;
    chk("rx_db_ready_off", bus.db_ready, 0);
    chk("rx_idle", bus.idle, 1);
    apb(0, 9'h102, 8'h00, 0, 8'h23);
    for (int i = 0; i < 4; i++)
      apb(0, 9'h010 + 9'(i), 8'h00, 0, 8'(8'h11 * (i + 1)));

    // RX overflow: 20 bytes offered, no burst_last
    apb(1, 9'h101, 8'h02, 0, 8'h00);
    acc = 0;
    for (int i = 0; i < 20; i++) begin
      bus.data_burst_in = 8'h60 + 8'(i);
      bus.burst_valid = 1'b1;
      if (bus.db_ready) acc++;
      @(posedge clk); #1;
    end
    bus.burst_valid = 1'b0;
    chk("ovf_accepted", acc, 16);
    chk("ovf_db_ready_off", bus.db_ready, 0);
    apb(0, 9'h102, 8'h00, 0, 8'h83);
    apb(0, 9'h010, 8'h00, 0, 8'h60);
    apb(0, 9'h01F, 8'h00, 0, 8'h6F);

    // Error cases
    apb(1, 9'h100, 8'h00, 1, 8'h00);
    apb(1, 9'h100, 8'h11, 1, 8'h00);
    apb(0, 9'h100, 8'h00, 0, 8'h03);
    apb(1, 9'h010, 8'h55, 1, 8'h00);
    apb(0, 9'h010, 8'h00, 0, 8'h60);
    apb(1, 9'h102, 8'h00, 1, 8'h00);
    apb(0, 9'h1FF, 8'h00, 1, 8'h00);
    apb(1, 9'h101, 8'h03, 1, 8'h00);
    chk("ctrl3_idle", bus.idle, 1);
    apb(0, 9'h102, 8'h00, 0, 8'h83);

    // TXBUF/LEN writes during TX are rejected and the burst is unchanged
    bus.burst_ready = 1'b0;
    push_abc3();
    apb(1, 9'h101, 8'h01, 0, 8'h00);
    bus.burst_ready = 1'b1;
    @(posedge clk); #1;
    bus.burst_ready = 1'b0;
    chk("in_tx_valid", bus.db_valid, 1);
    apb(1, 9'h001, 8'hEE, 1, 8'h00);
    apb(1, 9'h100, 8'h02, 1, 8'h00);
    apb(1, 9'h101, 8'h02, 1, 8'h00);
    bus.burst_ready = 1'b1;
    wait_idle(20, "busy_tx_idle");
    chk("busy_q_drained", tx_q.size(), 0);
    apb(0, 9'h001, 8'h00, 0, 8'hB2);

    // Reset mid-RX restores everything
    apb(1, 9'h101, 8'h02, 0, 8'h00);
    bus.data_burst_in = 8'h99; bus.burst_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    bus.burst_valid = 1'b0;
    @(posedge clk); #1;
    chk("midrst_state", {bus.idle, bus.db_ready, bus.db_valid}, 3'b100);
    rst_n = 1'b1;
    apb(0, 9'h100, 8'h00, 0, 8'h01);
    apb(0, 9'h010, 8'h00, 0, 8'h00);
    apb(0, 9'h000, 8'h00, 0, 8'h00);
    apb(0, 9'h102, 8'h00, 0, 8'h01);

    repeat (2) @(posedge clk);
    chk("apb_q_drained", apb_q.size(), 0);
    chk("tx_q_final", tx_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
